lc3_mem_unit: RTL and testbench
===============================

# lc3_mem_unit

Memory responder for the LC-3 datapath: services the read/write requests the control unit issues with `mem_en`/`mem_rw`, using the MAR address and MDR write data. It returns read data to the MDR and signals completion with the ready flag R. It holds word-addressed RAM and the keyboard/display memory-mapped device registers.

## Interface
- `DEPTH_LOG2`, default 10: RAM holds 2^DEPTH_LOG2 16-bit words.
- `LATENCY`, default 2: clock edges from request acceptance to completion; legal values are 1 and up.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mem_en`  in  1  access request.
- `mem_rw`  in  1  1 = write, 0 = read.
- `addr`  in  16  address from MAR.
- `wdata`  in  16  write data from MDR.
- `rdata`  out  16  read data to MDR.
- `mem_r`  out  1  ready: access complete, one-cycle pulse.
- `kbd_valid`  in  1  keyboard character strobe.
- `kbd_data`  in  8  keyboard character.
- `disp_valid`  out  1  display character pending.
- `disp_data`  out  8  display character.
- `disp_ready`  in  1  display consumes `disp_data` when high together with `disp_valid`.

## Operation
- FSM states are IDLE, BUSY and HOLD.
- **IDLE:** when `mem_en`=1 at an edge, latch `addr`, `wdata` and `mem_rw`. Go to BUSY with counter = LATENCY-1. With LATENCY=1, complete on the next edge.
- **BUSY:** the counter decrements each edge. When the counter reaches 0 at an edge, the access completes:
  - `mem_r`=1 for exactly that following cycle.
  - On a read, `rdata` is loaded.
  - On a write, the target is updated.
  - Next state is HOLD.
- **HOLD:** stays until `mem_en`=0 is sampled, then goes to IDLE. This prevents a held `mem_en` from causing a second access. New requests are accepted only from IDLE.
- Changes on `addr`, `wdata` or `mem_rw` after acceptance are ignored.
- Address decode uses the latched address:
  - xFE00 KBSR: bit15 = kbd flag, other bits 0. Read-only; writes are ignored.
  - xFE02 KBDR: {8'h00, kbd char}. A completed read clears the kbd flag. Writes are ignored.
  - xFE04 DSR: bit15 = ~`disp_valid`, other bits 0. Read-only.
  - xFE06 DDR: a write with `disp_valid`=0 loads `disp_data`=wdata[7:0] and sets `disp_valid`. A write with `disp_valid`=1 is dropped, but still completes with `mem_r`. Reads return {8'h00, `disp_data`}.
  - Any other address at xFE00 or above reads 0; writes are ignored.
  - Addresses below xFE00 go to RAM at addr[DEPTH_LOG2-1:0]. Higher address bits alias.
- Keyboard: `kbd_valid`=1 at an edge loads the kbd char and sets the flag. A new character overwrites an unread one.
- Display: `disp_valid`&`disp_ready` at an edge clears `disp_valid`.
- `rdata` holds its value until the next completed read. Writes do not change it.

## Timing
- On reset: `mem_r`=0, `rdata`=0, `disp_valid`=0, `disp_data`=0, kbd flag=0, kbd char=0, state IDLE.
- RAM is not reset; its contents are undefined.
- Reset asserted mid-access aborts the access. Nothing is written unless the completion edge already occurred.
- Latency: request sampled at edge k gives `mem_r` high from edge k+LATENCY to edge k+LATENCY+1, with `rdata` valid at the same time. All outputs are registered.
- Simultaneous events:
  - `kbd_valid` on the same edge as a KBDR read completion: the read returns the old char, the new char is stored, and the flag stays 1.
  - `disp_ready` consumption on the same edge as a DDR write completion: consumption is applied first, so the write is accepted and `disp_valid` stays 1 with the new data.
  - `mem_en` dropping while in BUSY does not cancel the access.

## Test plan
- **Reset:** assert `rst_n`=0 mid-BUSY -> all outputs 0 and state IDLE immediately. The next access behaves normally.
- **RAM:** write x1234 to x0040, then read x0040 -> `rdata`=x1234 with `mem_r` high exactly 2 cycles after acceptance (LATENCY=2). Read x0440 (alias) -> x1234.
- **Hold:** keep `mem_en`=1 for 6 cycles -> exactly one `mem_r` pulse. Drop `mem_en` for one cycle and re-raise it -> a second pulse.
- **Keyboard:**
  - `kbd_valid` with x41 -> KBSR read = x8000, then KBDR read = x0041, then KBSR read = x0000.
  - `kbd_valid` x42 on the same edge as KBDR completion -> read returns x0041 and KBSR = x8000.
- **Display:**
  - Write DDR x0058 with `disp_ready`=0 -> `disp_valid`=1, `disp_data`=x58, DSR=x0000.
  - A second DDR write x0059 -> dropped; `disp_data` stays x58.
  - `disp_ready`=1 -> `disp_valid` clears and DSR=x8000.
- **Unmapped:** write xFFFF to xFE10, then read it -> x0000. RAM location x0210 is unchanged.

Source files
------------

// File: rtl/lc3_mem_unit.sv
// LC-3 memory responder: word RAM plus keyboard/display device registers,
// serviced through an IDLE/BUSY/HOLD handshake with a fixed access latency.
module lc3_mem_unit #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_en,
    input  logic        mem_rw,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        mem_r,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [15:0] ADDR_IO   = 16'hFE00;
    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [15:0]           addr_r;
    logic [15:0]           wdata_r;
    logic                  rw_r;
    logic [15:0]           rdata_r;
    logic                  mem_r_r;
    logic                  kbd_flag_r;
    logic [7:0]            kbd_char_r;
    logic                  disp_valid_r;
    logic [7:0]            disp_data_r;
    logic [15:0]           ram [0:DEPTH-1];

    logic                  accept_s;
    logic                  complete_s;
    logic                  is_ram_s;
    logic [DEPTH_LOG2-1:0] ram_idx_s;
    logic [15:0]           io_rdata_s;
    logic                  ram_we_s;
    logic                  ddr_wr_s;
    logic                  kbdr_rd_s;
    logic                  disp_consume_s;

    assign is_ram_s       = (addr_r < ADDR_IO);
    assign ram_idx_s      = addr_r[DEPTH_LOG2-1:0];
    assign ram_we_s       = complete_s & rw_r & is_ram_s;
    assign ddr_wr_s       = complete_s & rw_r & (addr_r == ADDR_DDR);
    assign kbdr_rd_s      = complete_s & ~rw_r & (addr_r == ADDR_KBDR);
    assign disp_consume_s = disp_valid_r & disp_ready;

    assign rdata      = rdata_r;
    assign mem_r      = mem_r_r;
    assign disp_valid = disp_valid_r;
    assign disp_data  = disp_data_r;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; HOLD waits for mem_en to drop so a held request is served once
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        complete_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_en) begin
                    accept_s    = 1'b1;
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == CNT_ZERO) begin
                    complete_s  = 1'b1;
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            HOLD: begin
                if (!mem_en) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Request latch and latency counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= CNT_ZERO;
            addr_r  <= 16'h0000;
            wdata_r <= 16'h0000;
            rw_r    <= 1'b0;
        end else if (accept_s) begin
            cnt_r   <= CNT_INIT;
            addr_r  <= addr;
            wdata_r <= wdata;
            rw_r    <= mem_rw;
        end else if ((state_r == BUSY) && (cnt_r != CNT_ZERO)) begin
            cnt_r <= cnt_r - CNT_ONE;
        end
    end

    // Device register read mux on the latched address
    always_comb begin
        io_rdata_s = 16'h0000;
        case (addr_r)
            ADDR_KBSR: io_rdata_s = {kbd_flag_r, 15'h0000};
            ADDR_KBDR: io_rdata_s = {8'h00, kbd_char_r};
            ADDR_DSR:  io_rdata_s = {~disp_valid_r, 15'h0000};
            ADDR_DDR:  io_rdata_s = {8'h00, disp_data_r};
            default:   io_rdata_s = 16'h0000;
        endcase
    end

    // RAM array is deliberately left without reset
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram[ram_idx_s] <= wdata_r;
        end
    end

    // Completion pulse and read data return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r_r <= 1'b0;
            rdata_r <= 16'h0000;
        end else begin
            mem_r_r <= complete_s;
            if (complete_s && !rw_r) begin
                rdata_r <= is_ram_s ? ram[ram_idx_s] : io_rdata_s;
            end
        end
    end

    // Keyboard: a new strobe wins over the flag clear of a same-edge KBDR read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kbd_flag_r <= 1'b0;
            kbd_char_r <= 8'h00;
        end else if (kbd_valid) begin
            kbd_flag_r <= 1'b1;
            kbd_char_r <= kbd_data;
        end else if (kbdr_rd_s) begin
            kbd_flag_r <= 1'b0;
        end
    end

    // Display: same-edge consumption frees the slot for an incoming DDR write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_valid_r <= 1'b0;
            disp_data_r  <= 8'h00;
        end else if (ddr_wr_s && (!disp_valid_r || disp_ready)) begin
            disp_valid_r <= 1'b1;
            disp_data_r  <= wdata_r[7:0];
        end else if (disp_consume_s) begin
            disp_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lc3_mem_unit.sv
// Randomized self-checking bench for lc3_mem_unit against a transaction-level model.
module tb_lc3_mem_unit;

    localparam int DL  = 10;
    localparam int LAT = 2;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        mem_en     = 1'b0;
    logic        mem_rw     = 1'b0;
    logic [15:0] addr       = 16'h0000;
    logic [15:0] wdata      = 16'h0000;
    logic        kbd_valid  = 1'b0;
    logic [7:0]  kbd_data   = 8'h00;
    logic        disp_ready = 1'b0;
    logic [15:0] rdata;
    logic        mem_r;
    logic        disp_valid;
    logic [7:0]  disp_data;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [15:0] m_ram [int];
    logic [15:0] m_rdata    = 16'h0000;
    bit          m_rd_known = 1'b1;
    bit          m_kflag    = 1'b0;
    logic [7:0]  m_kchar    = 8'h00;
    bit          m_dv       = 1'b0;
    logic [7:0]  m_dd       = 8'h00;

    lc3_mem_unit #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .mem_en(mem_en), .mem_rw(mem_rw),
        .addr(addr), .wdata(wdata), .rdata(rdata), .mem_r(mem_r),
        .kbd_valid(kbd_valid), .kbd_data(kbd_data),
        .disp_valid(disp_valid), .disp_data(disp_data), .disp_ready(disp_ready)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_rdata = 16'h0000; m_rd_known = 1'b1;
        m_kflag = 1'b0; m_kchar = 8'h00; m_dv = 1'b0; m_dd = 8'h00;
    endtask

    // One whole transaction at the level of the register map.
    task automatic model_access(input bit rw, input logic [15:0] a, input logic [15:0] wd,
                                input bit skbd, input logic [7:0] kch, input bit sdisp, input bit rdy);
        int idx;
        if (rdy || sdisp) m_dv = 1'b0;
        if (a < 16'hFE00) begin
            idx = int'(a[DL-1:0]);
            if (rw) m_ram[idx] = wd;
            else if (m_ram.exists(idx)) begin m_rdata = m_ram[idx]; m_rd_known = 1'b1; end
            else m_rd_known = 1'b0;
        end else if (!rw) begin
            case (a)
                16'hFE00: m_rdata = m_kflag ? 16'h8000 : 16'h0000;
                16'hFE02: begin m_rdata = {8'h00, m_kchar}; m_kflag = 1'b0; end
                16'hFE04: m_rdata = m_dv ? 16'h0000 : 16'h8000;
                16'hFE06: m_rdata = {8'h00, m_dd};
                default:  m_rdata = 16'h0000;
            endcase
            m_rd_known = 1'b1;
        end else if (a == 16'hFE06 && !m_dv) begin
            m_dd = wd[7:0]; m_dv = 1'b1;
        end
        if (skbd) begin m_kchar = kch; m_kflag = 1'b1; end
        if (rdy) m_dv = 1'b0;
    endtask

    // Starts and ends at posedge+1; optional side events land on the completion edge.
    task automatic do_access(input bit rw, input logic [15:0] a, input logic [15:0] wd,
                             input bit skbd, input logic [7:0] kch, input bit sdisp, input bit rdy,
                             output logic [15:0] got);
        int n;
        bit seen;
        mem_en = 1'b1; mem_rw = rw; addr = a; wdata = wd; disp_ready = rdy;
        @(posedge clk); #1;
        mem_en = 1'b0; mem_rw = ~rw; addr = 16'($urandom); wdata = 16'($urandom);
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            if (n == LAT - 1) begin
                if (skbd) begin kbd_valid = 1'b1; kbd_data = kch; end
                if (sdisp) disp_ready = 1'b1;
            end
            @(posedge clk); #1;
            n++;
            kbd_valid = 1'b0;
            if (!rdy) disp_ready = 1'b0;
            if (mem_r) seen = 1'b1;
        end
        got = rdata;
        model_access(rw, a, wd, skbd, kch, sdisp, rdy);
        total++;
        if (!seen || n != LAT) begin
            bad++; $display("FAIL latency addr=%h: got %0d cycles (seen=%0d), need %0d", a, n, seen, LAT);
        end
        total++;
        if (m_rd_known && got !== m_rdata) begin
            bad++; $display("FAIL rdata addr=%h rw=%0d: got %h, need %h", a, rw, got, m_rdata);
        end
        @(posedge clk); #1;
        disp_ready = 1'b0;
        total++;
        if (mem_r !== 1'b0) begin
            bad++; $display("FAIL pulse_width addr=%h: mem_r=%b, need 0", a, mem_r);
        end
        total++;
        if (disp_valid !== m_dv || disp_data !== m_dd) begin
            bad++; $display("FAIL disp_state: got v=%b d=%h, need v=%b d=%h", disp_valid, disp_data, m_dv, m_dd);
        end
    endtask

    task automatic kbd_pulse(input logic [7:0] c);
        kbd_valid = 1'b1; kbd_data = c;
        @(posedge clk); #1;
        kbd_valid = 1'b0;
        m_kchar = c; m_kflag = 1'b1;
    endtask

    task automatic disp_consume();
        disp_ready = 1'b1;
        @(posedge clk); #1;
        disp_ready = 1'b0;
        m_dv = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] got;
        @(posedge clk); #1;
        total++;
        if (mem_r !== 1'b0 || rdata !== 16'h0000 || disp_valid !== 1'b0 || disp_data !== 8'h00) begin
            bad++; $display("FAIL reset_outputs: got r=%b rd=%h dv=%b dd=%h, need all 0", mem_r, rdata, disp_valid, disp_data);
        end
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        do_access(1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, got);
        total++;
        if (got !== 16'h0000) begin bad++; $display("FAIL reset_kbsr: got %h, need 0000", got); end
        do_access(1'b0, 16'hFE04, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, got);
        total++;
        if (got !== 16'h8000) begin bad++; $display("FAIL reset_dsr: got %h, need 8000", got); end
    endtask

    task automatic test_ram();
        logic [15:0] got;
        do_access(1'b1, 16'h0040, 16'h1234, 1'b0, 8'h00, 1'b0, 1'b0, got);
        total++;
        if (got !== 16'h8000) begin bad++; $display("FAIL write_keeps_rdata: got %h, need 8000", got); end
        do_access(1'b0, 16'h0040, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, got);
        total++;
        if (got !== 16'h1234) begin bad++; $display("FAIL ram_read: got %h, need 1234", got); end
        do_access(1'b0, 16'h0440, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, got);
        total++;
        if (got !== 16'h1234) begin bad++; $display("FAIL ram_alias: got %h, need 1234", got); end
    endtask

    task automatic test_hold();
        int pulses;
        mem_en = 1'b1; mem_rw = 1'b0; addr = 16'h0040;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (mem_r) pulses++;
        end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL hold_single: got %0d pulses, need 1", pulses); end
        mem_en = 1'b0;
        @(posedge clk); #1;
        mem_en = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (mem_r) pulses++;
        end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL hold_rearm: got %0d pulses, need 1", pulses); end
        total++;
        if (rdata !== 16'h1234) begin bad++; $display("FAIL hold_rdata: got %h, need 1234", rdata); end
        mem_en = 1'b0;
        m_rdata = 16'h1234; m_rd_known = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_kbd();
        logic [15:0] got;
        kbd_pulse(8'h41);
        do_access(1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, got);
        total++;
        if (got !== 16'h8000) begin bad++; $display("FAIL kbsr_set: got %h, need 8000", got); end
        do_access(1'b0, 16'hFE02, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, got);
        total++;
        if (got !== 16'h0041) begin bad++; $display("FAIL kbdr_read: got %h, need 0041", got); end
        do_access(1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, got);
        total++;
        if (got !== 16'h0000) begin bad++; $display("FAIL kbsr_clear: got %h, need 0000", got); end
        do_access(1'b0, 16'hFE02, 16'h0000, 1'b1, 8'h42, 1'b0, 1'b0, got);
        total++;
        if (got !== 16'h0041) begin bad++; $display("FAIL kbdr_same_edge: got %h, need 0041", got); end
        do_access(1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, got);
        total++;
        if (got !== 16'h8000) begin bad++; $display("FAIL kbsr_same_edge: got %h, need 8000", got); end
        do_access(1'b0, 16'hFE02, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, got);
        total++;
        if (got !== 16'h0042) begin bad++; $display("FAIL kbdr_new: got %h, need 0042", got); end
    endtask

    task automatic test_disp();
        logic [15:0] got;
        do_access(1'b1, 16'hFE06, 16'h0058, 1'b0, 8'h00, 1'b0, 1'b0, got);
        total++;
        if (disp_valid !== 1'b1 || disp_data !== 8'h58) begin
            bad++; $display("FAIL ddr_write: got v=%b d=%h, need v=1 d=58", disp_valid, disp_data);
        end
        do_access(1'b0, 16'hFE04, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, got);
        total++;
        if (got !== 16'h0000) begin bad++; $display("FAIL dsr_busy: got %h, need 0000", got); end
        do_access(1'b1, 16'hFE06, 16'h0059, 1'b0, 8'h00, 1'b0, 1'b0, got);
        total++;
        if (disp_data !== 8'h58) begin bad++; $display("FAIL ddr_drop: got %h, need 58", disp_data); end
        disp_consume();
        total++;
        if (disp_valid !== 1'b0) begin bad++; $display("FAIL disp_consume: got %b, need 0", disp_valid); end
        do_access(1'b0, 16'hFE04, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, got);
        total++;
        if (got !== 16'h8000) begin bad++; $display("FAIL dsr_free: got %h, need 8000", got); end
        do_access(1'b1, 16'hFE06, 16'h0061, 1'b0, 8'h00, 1'b0, 1'b0, got);
        do_access(1'b1, 16'hFE06, 16'h0062, 1'b0, 8'h00, 1'b1, 1'b0, got);
        total++;
        if (disp_valid !== 1'b1 || disp_data !== 8'h62) begin
            bad++; $display("FAIL ddr_same_edge: got v=%b d=%h, need v=1 d=62", disp_valid, disp_data);
        end
        do_access(1'b0, 16'hFE06, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, got);
        total++;
        if (got !== 16'h0062) begin bad++; $display("FAIL ddr_read: got %h, need 0062", got); end
        disp_consume();
    endtask

    task automatic test_unmapped();
        logic [15:0] got;
        do_access(1'b1, 16'h0210, 16'hBEEF, 1'b0, 8'h00, 1'b0, 1'b0, got);
        do_access(1'b1, 16'hFE10, 16'hFFFF, 1'b0, 8'h00, 1'b0, 1'b0, got);
        do_access(1'b0, 16'hFE10, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, got);
        total++;
        if (got !== 16'h0000) begin bad++; $display("FAIL unmapped_read: got %h, need 0000", got); end
        do_access(1'b0, 16'h0210, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, got);
        total++;
        if (got !== 16'hBEEF) begin bad++; $display("FAIL unmapped_no_alias: got %h, need beef", got); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] got;
        kbd_pulse(8'h33);
        do_access(1'b1, 16'hFE06, 16'h0077, 1'b0, 8'h00, 1'b0, 1'b0, got);
        do_access(1'b1, 16'h0080, 16'hAAAA, 1'b0, 8'h00, 1'b0, 1'b0, got);
        do_access(1'b0, 16'h0080, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, got);
        mem_en = 1'b1; mem_rw = 1'b1; addr = 16'h0080; wdata = 16'h5555;
        @(posedge clk); #1;
        mem_en = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (mem_r !== 1'b0 || rdata !== 16'h0000 || disp_valid !== 1'b0 || disp_data !== 8'h00) begin
            bad++; $display("FAIL reset_mid: got r=%b rd=%h dv=%b dd=%h, need all 0", mem_r, rdata, disp_valid, disp_data);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        do_access(1'b0, 16'h0080, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, got);
        total++;
        if (got !== 16'hAAAA) begin bad++; $display("FAIL reset_abort_write: got %h, need aaaa", got); end
        do_access(1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, got);
        total++;
        if (got !== 16'h0000) begin bad++; $display("FAIL reset_mid_kbsr: got %h, need 0000", got); end
    endtask

    task automatic test_random();
        logic [15:0] got;
        logic [15:0] io_tab [8];
        logic [15:0] a;
        bit          rw;
        io_tab = '{16'hFE00, 16'hFE02, 16'hFE04, 16'hFE06, 16'hFE10, 16'hFFFF, 16'hFE01, 16'hFE08};
        for (int j = 0; j < 16; j++) begin
            do_access(1'b1, 16'(j * 37 + 5), 16'($urandom), 1'b0, 8'h00, 1'b0, 1'b0, got);
        end
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 1) == 0)
                a = 16'(($urandom_range(0, 62) << 10) | ($urandom_range(0, 15) * 37 + 5));
            else
                a = io_tab[$urandom_range(0, 7)];
            rw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) kbd_pulse(8'($urandom));
            do_access(rw, a, 16'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), got);
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_hold();
        test_kbd();
        test_disp();
        test_unmapped();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
